// File: rtl/vdp_vram_arbiter_if.sv
// Request/acknowledge and VRAM-port signal bundle for the V9958 VRAM slot arbiter.
// The arbiter uses the slave view; requesters and the VRAM model use the master view.
interface vdp_vram_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_address;
  logic              spr_req;
  logic [ADDR_W-1:0] spr_address;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cmd_req;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_wdata;
  logic              disp_ack;
  logic              spr_ack;
  logic              cpu_ack;
  logic              cmd_ack;
  logic [DATA_W-1:0] rdata;
  logic              vram_valid;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_address;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_rdata;

  modport slave (
    input  disp_req, disp_address, spr_req, spr_address,
    input  cpu_req, cpu_we, cpu_address, cpu_wdata,
    input  cmd_req, cmd_we, cmd_address, cmd_wdata, vram_rdata,
    output disp_ack, spr_ack, cpu_ack, cmd_ack, rdata,
    output vram_valid, vram_we, vram_address, vram_wdata
  );

  modport master (
    output disp_req, disp_address, spr_req, spr_address,
    output cpu_req, cpu_we, cpu_address, cpu_wdata,
    output cmd_req, cmd_we, cmd_address, cmd_wdata, vram_rdata,
    input  disp_ack, spr_ack, cpu_ack, cmd_ack, rdata,
    input  vram_valid, vram_we, vram_address, vram_wdata
  );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// Time-slot scheduler sharing the single VRAM port between display fetch, sprite fetch,
// CPU port and command engine; one slot opens every fourth enabled cycle (dot_state=3).
module vdp_vram_arbiter #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] dot_state,
  input  logic [2:0] eight_dot_state,
  input  logic       display_active,
  input  logic       sprite_active,
  vdp_vram_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StAccess} state_e;
  typedef enum logic [1:0] {OwnDisp, OwnSpr, OwnCpu, OwnCmd} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              done_q, done_d;
  logic              rr_cmd_q, rr_cmd_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        ack_q, ack_d;

  logic              slot_open, disp_slot, spr_slot;
  logic              sel_valid, contend, grant;
  owner_e            sel_owner;
  logic [ADDR_W-1:0] sel_address;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  assign slot_open = enable && (dot_state == 2'b11);
  assign disp_slot = display_active && (eight_dot_state <= 3'd5);
  assign spr_slot  = sprite_active && (eight_dot_state == 3'd6);

  // Reserved slots fall through to the CPU/command round robin when unused.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OwnCpu;
    contend   = 1'b0;
    if (disp_slot && bus.disp_req) begin
      sel_valid = 1'b1;
      sel_owner = OwnDisp;
    end else if (spr_slot && bus.spr_req) begin
      sel_valid = 1'b1;
      sel_owner = OwnSpr;
    end else if (bus.cpu_req && bus.cmd_req) begin
      sel_valid = 1'b1;
      contend   = 1'b1;
      sel_owner = rr_cmd_q ? OwnCmd : OwnCpu;
    end else if (bus.cpu_req) begin
      sel_valid = 1'b1;
      sel_owner = OwnCpu;
    end else if (bus.cmd_req) begin
      sel_valid = 1'b1;
      sel_owner = OwnCmd;
    end
  end

  always_comb begin
    sel_address = '0;
    sel_we      = 1'b0;
    sel_wdata   = '0;
    unique case (sel_owner)
      OwnDisp: sel_address = bus.disp_address;
      OwnSpr:  sel_address = bus.spr_address;
      OwnCpu: begin
        sel_address = bus.cpu_address;
        sel_we      = bus.cpu_we;
        sel_wdata   = bus.cpu_wdata;
      end
      OwnCmd: begin
        sel_address = bus.cmd_address;
        sel_we      = bus.cmd_we;
        sel_wdata   = bus.cmd_wdata;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    done_d   = done_q;
    rr_cmd_d = rr_cmd_q;
    valid_d  = valid_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = '0;
    grant    = 1'b0;
    unique case (state_q)
      StIdle: grant = slot_open && sel_valid;
      StAccess: begin
        if (!done_q) begin
          // Without a dot_state=2 phase the access simply stays open.
          if (enable && (dot_state == 2'b10)) begin
            done_d         = 1'b1;
            ack_d[owner_q] = 1'b1;
            if (!we_q) begin
              rdata_d = bus.vram_rdata;
            end
          end
        end else if (slot_open) begin
          state_d = StIdle;
          done_d  = 1'b0;
          valid_d = 1'b0;
          we_d    = 1'b0;
          grant   = sel_valid;
        end
      end
    endcase
    if (grant) begin
      state_d = StAccess;
      done_d  = 1'b0;
      owner_d = sel_owner;
      addr_d  = sel_address;
      we_d    = sel_we;
      wdata_d = sel_wdata;
      valid_d = 1'b1;
      if (contend) begin
        rr_cmd_d = ~rr_cmd_q;
      end
    end
  end

  // ack_q reloads every clk so a pulse never outlasts one clock while enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      owner_q  <= OwnCpu;
      done_q   <= 1'b0;
      rr_cmd_q <= 1'b0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      done_q   <= done_d;
      rr_cmd_q <= rr_cmd_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.disp_ack     = ack_q[OwnDisp];
  assign bus.spr_ack      = ack_q[OwnSpr];
  assign bus.cpu_ack      = ack_q[OwnCpu];
  assign bus.cmd_ack      = ack_q[OwnCmd];
  assign bus.rdata        = rdata_q;
  assign bus.vram_valid   = valid_q;
  assign bus.vram_we      = we_q;
  assign bus.vram_address = addr_q;
  assign bus.vram_wdata   = wdata_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter: expected accesses go into a scoreboard queue and a
// negedge monitor checks each ack against the queue head.
module tb_vdp_vram_arbiter;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam logic [1:0] WDisp = 2'd0;
  localparam logic [1:0] WSpr  = 2'd1;
  localparam logic [1:0] WCpu  = 2'd2;
  localparam logic [1:0] WCmd  = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] dot_state = 2'd0;
  logic [2:0] eight_dot_state = 3'd0;
  logic       display_active = 1'b0;
  logic       sprite_active = 1'b0;
  logic       toggle_en = 1'b0;

  vdp_vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vdp_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .dot_state       (dot_state),
    .eight_dot_state (eight_dot_state),
    .display_active  (display_active),
    .sprite_active   (sprite_active),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    who;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] who, input logic [AW-1:0] addr, input logic we,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] rd);
    exp_t e;
    if (!we) last_rd = rd;
    e.who = who; e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = last_rd;
    sb.push_back(e);
  endtask

  // Monitor: every ack must be one-hot, one clk wide, and match the scoreboard head.
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    logic [3:0] acks;
    exp_t       e;
    acks = {bus.cmd_ack, bus.cpu_ack, bus.spr_ack, bus.disp_ack};
    if (!reset_n) begin
      prev_ack = 1'b0;
    end else begin
      if (acks != 4'd0) begin
        check("ack_width", 32'(prev_ack), 32'd0);
        check("ack_onehot", 32'($countones(acks)), 32'd1);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: acks=%b, expected none at %0t", acks, $time);
        end else begin
          e = sb.pop_front();
          check("ack_owner", 32'(acks), 32'(4'b0001 << e.who));
          check("vram_address", 32'(bus.vram_address), 32'(e.addr));
          check("vram_we", 32'(bus.vram_we), 32'(e.we));
          if (e.we) check("vram_wdata", 32'(bus.vram_wdata), 32'(e.wdata));
          check("rdata", 32'(bus.rdata), 32'(e.rdata));
        end
      end
      prev_ack = (acks != 4'd0);
    end
  end

  // Sync-generator model: dot_state advances on enabled edges; group index steps after dot 3.
  task automatic tick();
    @(posedge clk);
    #1;
    if (enable) begin
      if (dot_state == 2'd3) eight_dot_state = eight_dot_state + 3'd1;
      dot_state = dot_state + 2'd1;
    end
    if (toggle_en) enable = ~enable;
  endtask

  task automatic align(input logic [2:0] g);
    int i = 0;
    while (!(dot_state == 2'd0 && eight_dot_state == g) && i < 80) begin
      tick();
      i++;
    end
    check("align", 32'(dot_state == 2'd0 && eight_dot_state == g), 32'd1);
  endtask

  task automatic wait_ack(input int budget);
    int   i = 0;
    logic got = 1'b0;
    while (!got && i < budget) begin
      tick();
      i++;
      got = bus.disp_ack | bus.spr_ack | bus.cpu_ack | bus.cmd_ack;
    end
    check("ack_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.disp_req = 1'b0; bus.disp_address = '0;
    bus.spr_req = 1'b0;  bus.spr_address = '0;
    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0; bus.cpu_address = '0; bus.cpu_wdata = '0;
    bus.cmd_req = 1'b0;  bus.cmd_we = 1'b0; bus.cmd_address = '0; bus.cmd_wdata = '0;
    bus.vram_rdata = '0;
    enable = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(bus.vram_valid), 32'd0);
    check("rst_we", 32'(bus.vram_we), 32'd0);
    check("rst_address", 32'(bus.vram_address), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_acks", 32'({bus.disp_ack, bus.spr_ack, bus.cpu_ack, bus.cmd_ack}), 32'd0);
    reset_n = 1'b1;

    // 1: reset in the middle of a CPU write, then the held request is served afterwards.
    align(3'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_address = 17'h00123; bus.cpu_wdata = 8'h77;
    repeat (4) tick();
    check("t1_valid", 32'(bus.vram_valid), 32'd1);
    check("t1_we", 32'(bus.vram_we), 32'd1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("t1_async_valid", 32'(bus.vram_valid), 32'd0);
    check("t1_async_we", 32'(bus.vram_we), 32'd0);
    check("t1_async_address", 32'(bus.vram_address), 32'd0);
    check("t1_async_wdata", 32'(bus.vram_wdata), 32'd0);
    check("t1_async_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    last_rd = '0;
    push(WCpu, 17'h00123, 1'b1, 8'h77, 8'h00);
    wait_ack(40);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;

    // 2: display slots 0..5 go to disp, slots 6 and 7 fall to the CPU.
    display_active = 1'b1;
    bus.vram_rdata = 8'h11;
    align(3'd0);
    bus.disp_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_address = 17'h0F0F0;
    for (int s = 0; s < 8; s++) begin
      bus.disp_address = 17'h00400 + 17'(s);
      if (s < 6) push(WDisp, 17'h00400 + 17'(s), 1'b0, 8'h00, 8'h11);
      else       push(WCpu, 17'h0F0F0, 1'b0, 8'h00, 8'h11);
      repeat (4) tick();
    end
    bus.disp_req = 1'b0; bus.cpu_req = 1'b0;
    repeat (4) tick();
    display_active = 1'b0;

    // 3: CPU and command engine contend; grants alternate starting with the CPU.
    bus.vram_rdata = 8'h22;
    align(3'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 17'h00111;
    bus.cmd_req = 1'b1; bus.cmd_we = 1'b1; bus.cmd_address = 17'h00222; bus.cmd_wdata = 8'h3C;
    for (int s = 0; s < 8; s++) begin
      if (s % 2 == 0) push(WCpu, 17'h00111, 1'b0, 8'h00, 8'h22);
      else            push(WCmd, 17'h00222, 1'b1, 8'h3C, 8'h00);
      repeat (4) tick();
    end
    bus.cpu_req = 1'b0; bus.cmd_req = 1'b0; bus.cmd_we = 1'b0;
    repeat (4) tick();

    // 4: CPU read latency and valid window.
    bus.vram_rdata = 8'h5A;
    align(3'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_address = 17'h1ABCD;
    push(WCpu, 17'h1ABCD, 1'b0, 8'h00, 8'h5A);
    repeat (3) tick();
    check("t4_pre_valid", 32'(bus.vram_valid), 32'd0);
    tick();
    check("t4_grant_valid", 32'(bus.vram_valid), 32'd1);
    check("t4_grant_address", 32'(bus.vram_address), 32'h1ABCD);
    tick();
    check("t4_ack_c1", 32'(bus.cpu_ack), 32'd0);
    tick();
    check("t4_ack_c2", 32'(bus.cpu_ack), 32'd0);
    tick();
    check("t4_ack_c3", 32'(bus.cpu_ack), 32'd1);
    check("t4_rdata", 32'(bus.rdata), 32'h5A);
    check("t4_valid_c3", 32'(bus.vram_valid), 32'd1);
    bus.cpu_req = 1'b0;
    tick();
    check("t4_valid_end", 32'(bus.vram_valid), 32'd0);
    check("t4_ack_end", 32'(bus.cpu_ack), 32'd0);

    // 5: command write leaves rdata untouched.
    bus.vram_rdata = 8'hEE;
    align(3'd0);
    bus.cmd_req = 1'b1; bus.cmd_we = 1'b1; bus.cmd_address = 17'h00010; bus.cmd_wdata = 8'hC3;
    push(WCmd, 17'h00010, 1'b1, 8'hC3, 8'h00);
    repeat (4) tick();
    check("t5_we", 32'(bus.vram_we), 32'd1);
    check("t5_wdata", 32'(bus.vram_wdata), 32'hC3);
    wait_ack(8);
    bus.cmd_req = 1'b0; bus.cmd_we = 1'b0;
    check("t5_rdata_kept", 32'(bus.rdata), 32'h5A);
    tick();
    check("t5_single_ack", 32'(bus.cmd_ack), 32'd0);

    // 6: enable toggles every clk; sprite requests are served only in slot 6.
    sprite_active = 1'b1;
    bus.vram_rdata = 8'h99;
    align(3'd0);
    bus.spr_req = 1'b1; bus.spr_address = 17'h1F000;
    push(WSpr, 17'h1F000, 1'b0, 8'h00, 8'h99);
    push(WSpr, 17'h1F000, 1'b0, 8'h00, 8'h99);
    toggle_en = 1'b1;
    repeat (128) tick();
    bus.spr_req = 1'b0;
    toggle_en = 1'b0;
    enable = 1'b1;
    repeat (8) tick();
    sprite_active = 1'b0;

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vdp_vram_arbiter.md
Name: vdp_vram_arbiter

Overview:
- Time-slot scheduler for the single VRAM port of the V9958 core.
- Shares the port between four requesters: display fetch, sprite fetch, CPU port and command engine.
- Slot boundaries come from the sync generator's dot_state and eight_dot_state.
- Sits between the sync generator / fetch units and the VRAM interface.

Parameters:
ADDR_W, 17, VRAM address width (128 KiB)
DATA_W, 8, VRAM data width

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  clock enable; all state advances only when enable=1
dot_state  input  2  dot phase from sync generator
eight_dot_state  input  3  slot index within 8-dot group
display_active  input  1  display fetch window (active line, pre-fetch included)
sprite_active  input  1  sprite fetch window
disp_req / spr_req  input  1  read requests, level, held until ack
disp_address / spr_address  input  ADDR_W  read addresses
cpu_req, cmd_req  input  1  requests, level, held until ack
cpu_we, cmd_we  input  1  1=write
cpu_address, cmd_address  input  ADDR_W  addresses
cpu_wdata, cmd_wdata  input  DATA_W  write data
disp_ack, spr_ack, cpu_ack, cmd_ack  output  1  one-enable-cycle completion pulse
rdata  output  DATA_W  latched read data, valid from ack onward
vram_valid  output  1  access in progress
vram_we  output  1  write strobe qualifier
vram_address  output  ADDR_W  VRAM address
vram_wdata  output  DATA_W  VRAM write data
vram_rdata  input  DATA_W  VRAM read data

Behaviour:
- Reset (reset_n=0, async):
  - All outputs are 0.
  - The round-robin pointer is set to CPU.
  - State is IDLE.
- Slot open: an enabled cycle with dot_state=2'b11. Exactly one slot per 4 enabled cycles.
- Slot class at slot open:
  - display_active=1 and eight_dot_state 0..5: DISP slot.
  - sprite_active=1 and eight_dot_state=6: SPR slot.
  - Otherwise: FREE slot.
- Owner selection:
  - DISP slot: disp if disp_req, else fall through to FREE rules.
  - SPR slot: spr if spr_req, else fall through to FREE rules.
  - FREE slot: cpu or cmd. If both request, the round-robin pointer decides and then flips to the other requester. A single requester wins without moving the pointer.
  - disp_req in a FREE slot and spr_req outside an SPR slot are never served.
- State machine IDLE -> ACCESS -> IDLE.
  - IDLE: at slot open with a selected owner, register owner, address, we and wdata. Set vram_valid=1 and vram_we=owner_we. Go to ACCESS.
  - ACCESS: outputs held stable for 4 enabled cycles.
  - Completion: on the next enabled cycle with dot_state=2'b10, sample vram_rdata into rdata (reads only; writes leave rdata unchanged) and pulse the owner's ack for that one cycle.
  - Following enabled cycle (dot_state=2'b11): clear vram_valid and vram_we, return to IDLE. A new grant may be issued in that same cycle, so back-to-back slots are allowed.
- Latency: grant to ack is 3 enabled cycles. Request to grant depends on slot class.
- A req dropped before grant is not served. A req dropped after grant is still completed, and the ack is ignored.
- enable=0 freezes all state and outputs. An ack pulse is not stretched; it lasts exactly one clk because enable gates generation.
- Simultaneous ack and new req from the same requester: the new req is eligible from the next slot open.
- dot_state sequence anomaly (no 2'b10 while in ACCESS): remain in ACCESS until it occurs. No timeout.

Test Plan:
1. Reset mid-access: assert reset_n=0 during ACCESS of a cpu write -> all outputs 0 asynchronously, no cpu_ack; after release, the first slot grants the still-pending cpu_req.
2. display_active=1, disp_req and cpu_req held, eight_dot_state cycling 0..7 -> disp granted in slots 0..5, cpu in 6 and 7 (sprite_active=0). vram_address equals disp_address in the disp slots.
3. cpu_req and cmd_req both held, display_active=0, 8 slots -> grants alternate cpu, cmd, cpu, … (4 each).
4. CPU read of 0x1ABCD with vram_rdata=8'h5A -> vram_valid for 4 enabled cycles; cpu_ack 3 enabled cycles after grant; rdata=8'h5A.
5. cmd write 0x00010 data 8'hC3 -> vram_we=1, vram_wdata=8'hC3; cmd_ack pulses once; rdata unchanged.
6. enable toggling 1/0 each clk with sprite_active=1, spr_req -> spr granted only at eight_dot_state=6; timing scales ×2 in clk; every ack is exactly 1 clk wide.
